pmod_port_arbiter: RTL and testbench
====================================

// Module: pmod_port_arbiter
// PURPOSE
//   Shares one 8-bit PMOD output port among NREQ on-chip requesters, e.g. RTC seconds digits,
//   SoC GPIO and debug pattern generator. Round-robin arbitration with minimum hold time,
//   timeout-forced release and a one-cycle turnaround gap. Sits in top between the requesters
//   and the pmod0 pins; all pin outputs are registered.
// PARAMETERS
//   NREQ       4      number of requesters (2..8)
//   WIDTH      8      port width in bits
//   HOLD_MIN   16     min cycles a grant is held once issued (>=1)
//   TIMEOUT    1024   cycles after which owner is forced off if another req is pending (>HOLD_MIN)
//   IDLE_VALUE 8'h00  value driven on port when no owner / during gap
// PORTS
//   clk          in   1             system clock (pll_clk domain)
//   reset        in   1             synchronous, active-high reset
//   req          in   NREQ          level request per requester
//   data_in      in   NREQ*WIDTH    requester i data at [i*WIDTH +: WIDTH]
//   grant        out  NREQ          one-hot grant (registered), all zero when no owner
//   owner        out  $clog2(NREQ)  index of current owner (valid when busy)
//   busy         out  1             port currently granted
//   timeout_evt  out  1             1-cycle pulse on forced release
//   pmod_out     out  WIDTH         registered port value to pins
// BEHAVIOUR
//   Reset: grant=0, owner=0, busy=0, timeout_evt=0, pmod_out=IDLE_VALUE, rr_ptr=0, state=IDLE.
//   States: IDLE -> GRANT -> GAP -> (GRANT | IDLE).
//   IDLE: if any req at cycle t, pick first requester at/after rr_ptr (wrapping); grant/busy/owner
//     valid at t+1, hold_cnt=0; else stay, pmod_out=IDLE_VALUE.
//   GRANT: pmod_out <= data_in[owner] every cycle (1-cycle register latency, first owner data
//     visible at t+2); hold_cnt saturating increment.
//     Release when hold_cnt>=HOLD_MIN-1 and req[owner]=0 -> GAP.
//     Req dropped before HOLD_MIN: grant kept, data still muxed, until HOLD_MIN reached.
//     Forced: hold_cnt>=TIMEOUT-1 and any other req=1 -> GAP, timeout_evt=1 that cycle.
//     No other req: owner keeps port indefinitely, no timeout.
//   GAP: exactly 1 cycle, grant=0, busy=0, pmod_out=IDLE_VALUE; rr_ptr=owner+1 mod NREQ.
//     Then arbitrate as IDLE in the same cycle: pending req -> GRANT next cycle, else IDLE.
//   Released owner still requesting is eligible again, lowest RR priority.
//   Simultaneous release + new req: gap always inserted; no back-to-back grant.
//   Reset mid-grant: all outputs return to reset values next edge, no gap cycle.
//   req of non-owners ignored while GRANT except for timeout evaluation.
// CONFIGURATION
//   PMOD_ARB_PRIORITY_EN defined: requester 0 is high priority. In IDLE/GAP it wins regardless
//     of rr_ptr. In GRANT (owner!=0), req[0]=1 with hold_cnt>=HOLD_MIN-1 forces release
//     (timeout_evt not pulsed); rr_ptr is not advanced by requester-0 grants.
//   Not defined: pure round-robin, requester 0 has no special treatment.
// TESTING
//   1 Reset, no req, 100 cycles -> pmod_out=8'h00, grant=0, busy=0 throughout.
//   2 req=4'b0010 at t, data_in[1]=8'hA5 -> grant=4'b0010 at t+1, pmod_out=8'hA5 at t+2;
//     req drop at t+3 -> grant held to t+16, pmod_out=8'h00 at t+17 gap.
//   3 req=4'b1111 held, never dropped, TIMEOUT=32 -> grants cycle 0,1,2,3,0 each 32 cycles;
//     1 gap cycle and timeout_evt pulse between each.
//   4 owner 2 alone, TIMEOUT exceeded by 500 cycles -> no release, timeout_evt never asserted.
//   5 reset asserted mid-grant of owner 3 -> next edge grant=0, pmod_out=IDLE_VALUE, rr_ptr=0.
//   6 PMOD_ARB_PRIORITY_EN: owner 2 granted, req[0]=1 at hold_cnt=5 -> release at hold_cnt=15;
//     gap; grant=4'b0001; without macro owner 2 keeps port until TIMEOUT.

Source files
------------

// File: rtl/pmod_port_arbiter.sv
// -----------------------------------------------------------------------------
// pmod_port_arbiter
//   Lets NREQ on-chip requesters share one WIDTH-bit PMOD output port.
//   Round-robin arbitration. Each grant is held for at least HOLD_MIN cycles.
//   An owner is forced off after TIMEOUT cycles, but only if another requester
//   is waiting. Every release is followed by one idle turnaround (gap) cycle.
//   All outputs are registered.
//
// Ports
//   clk          system clock (pll_clk domain)
//   reset        synchronous, active-high reset
//   req          level request per requester
//   data_in      data for requester i at [i*WIDTH +: WIDTH]
//   grant        one-hot grant, all zero when there is no owner
//   owner        index of the current owner (valid while busy)
//   busy         port currently granted
//   timeout_evt  one-cycle pulse, high in the gap cycle after a forced release
//   pmod_out     registered port value driven to the pins
//
// Optional feature
//   PMOD_ARB_PRIORITY_EN - requester 0 becomes high priority. It wins every
//   arbitration. Once the minimum hold has elapsed, it also pre-empts any
//   other owner. Grants to requester 0 do not move the round-robin pointer.
// -----------------------------------------------------------------------------
module pmod_port_arbiter #(
  parameter int              NREQ       = 4,
  parameter int              WIDTH      = 8,
  parameter int              HOLD_MIN   = 16,
  parameter int              TIMEOUT    = 1024,
  parameter logic [WIDTH-1:0] IDLE_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   data_in,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy,
  output logic                    timeout_evt,
  output logic [WIDTH-1:0]        pmod_out
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MIN - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [IW-1:0] LAST_REQ  = IW'(NREQ - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_GAP} state_t;

  state_t            state_reg, state_next;
  logic [NREQ-1:0]   grant_reg, grant_next;
  logic [IW-1:0]     owner_reg, owner_next;
  logic [IW-1:0]     rr_ptr_reg, rr_ptr_next;
  logic              busy_reg, busy_next;
  logic              timeout_evt_reg, timeout_evt_next;
  logic [CW-1:0]     hold_cnt_reg, hold_cnt_next;
  logic [WIDTH-1:0]  pmod_out_reg, pmod_out_next;

  logic [WIDTH-1:0]  data_arr [NREQ];
  logic              pick_valid;
  logic [IW-1:0]     pick_idx;
  logic [IW-1:0]     cand_idx;
  int                sum_idx;
  logic              hold_done, req_owner, other_req;
  logic              normal_rel, prio_rel, forced_rel;

  // Unpack the flat data bus into one lane per requester.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_lane
      assign data_arr[gi] = data_in[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Round-robin pick: first requester at or after rr_ptr, wrapping around.
  // The loop scans downward, so the candidate closest to rr_ptr is written last and wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    sum_idx    = 0;
    cand_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum_idx = int'(rr_ptr_reg) + k;
      if (sum_idx >= NREQ) begin
        sum_idx = sum_idx - NREQ;
      end
      cand_idx = IW'(sum_idx);
      if (req[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
`ifdef PMOD_ARB_PRIORITY_EN
    if (req[0]) begin
      pick_valid = 1'b1;
      pick_idx   = '0;
    end
`endif
  end

  // grant_reg is one-hot on the owner while granted, so it doubles as the owner mask.
  assign req_owner  = |(req & grant_reg);
  assign other_req  = |(req & ~grant_reg);
  assign hold_done  = (hold_cnt_reg >= HOLD_LAST);
  assign normal_rel = hold_done && !req_owner;
  assign forced_rel = (hold_cnt_reg >= TO_LAST) && other_req;
`ifdef PMOD_ARB_PRIORITY_EN
  assign prio_rel   = hold_done && req[0] && (owner_reg != '0);
`else
  assign prio_rel   = 1'b0;
`endif

  always_comb begin
    state_next       = state_reg;
    grant_next       = grant_reg;
    owner_next       = owner_reg;
    rr_ptr_next      = rr_ptr_reg;
    busy_next        = busy_reg;
    hold_cnt_next    = hold_cnt_reg;
    timeout_evt_next = 1'b0;
    pmod_out_next    = IDLE_VALUE;
    unique case (state_reg)
      ST_GRANT: begin
        if (normal_rel || prio_rel || forced_rel) begin
          state_next       = ST_GAP;
          grant_next       = '0;
          busy_next        = 1'b0;
          // Only a pure timeout counts as a forced release.
          timeout_evt_next = forced_rel && !normal_rel && !prio_rel;
          rr_ptr_next      = (owner_reg == LAST_REQ) ? '0 : owner_reg + 1'b1;
`ifdef PMOD_ARB_PRIORITY_EN
          if (owner_reg == '0) begin
            rr_ptr_next = rr_ptr_reg;
          end
`endif
        end else begin
          pmod_out_next = data_arr[owner_reg];
          if (hold_cnt_reg != CNT_MAX) begin
            hold_cnt_next = hold_cnt_reg + 1'b1;
          end
        end
      end
      default: begin
        // IDLE and GAP arbitrate the same way; GAP simply lasts one cycle.
        if (pick_valid) begin
          state_next    = ST_GRANT;
          grant_next    = NREQ'(1) << pick_idx;
          owner_next    = pick_idx;
          busy_next     = 1'b1;
          hold_cnt_next = '0;
        end else begin
          state_next = ST_IDLE;
          grant_next = '0;
          busy_next  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      grant_reg       <= '0;
      owner_reg       <= '0;
      rr_ptr_reg      <= '0;
      busy_reg        <= 1'b0;
      hold_cnt_reg    <= '0;
      timeout_evt_reg <= 1'b0;
      pmod_out_reg    <= IDLE_VALUE;
    end else begin
      state_reg       <= state_next;
      grant_reg       <= grant_next;
      owner_reg       <= owner_next;
      rr_ptr_reg      <= rr_ptr_next;
      busy_reg        <= busy_next;
      hold_cnt_reg    <= hold_cnt_next;
      timeout_evt_reg <= timeout_evt_next;
      pmod_out_reg    <= pmod_out_next;
    end
  end

  assign grant       = grant_reg;
  assign owner       = owner_reg;
  assign busy        = busy_reg;
  assign timeout_evt = timeout_evt_reg;
  assign pmod_out    = pmod_out_reg;

endmodule

// File: tb/tb_pmod_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pmod_port_arbiter
//   Testbench for pmod_port_arbiter.
//   A behavioural model tracks who owns the port and how many cycles it has
//   held it. Every cycle the DUT outputs are compared against the model.
//   Directed scenarios are followed by a randomized request/data phase.
// -----------------------------------------------------------------------------
module tb_pmod_port_arbiter;

  localparam int NREQ     = 4;
  localparam int WIDTH    = 8;
  localparam int HOLD_MIN = 16;
  localparam int TIMEOUT  = 32;
  localparam logic [WIDTH-1:0] IDLE = 8'h00;
`ifdef PMOD_ARB_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] data_in = '0;
  logic [NREQ-1:0]       grant;
  logic [1:0]            owner;
  logic                  busy;
  logic                  timeout_evt;
  logic [WIDTH-1:0]      pmod_out;

  always #5 clk = ~clk;

  pmod_port_arbiter #(
    .NREQ(NREQ), .WIDTH(WIDTH), .HOLD_MIN(HOLD_MIN), .TIMEOUT(TIMEOUT), .IDLE_VALUE(IDLE)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .data_in(data_in),
    .grant(grant), .owner(owner), .busy(busy), .timeout_evt(timeout_evt), .pmod_out(pmod_out)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: expected outputs for the current cycle.
  bit               m_busy;
  int               m_owner;
  int               m_age;   // cycles the owner has held the port, 1 on the first grant cycle
  int               m_ptr;   // requester with top round-robin priority
  bit               m_evt;
  logic [WIDTH-1:0] m_pmod;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit bit_at(input logic [NREQ-1:0] v, input int i);
    return ((v >> i) & NREQ'(1)) != '0;
  endfunction

  function automatic logic [NREQ*WIDTH-1:0] rand_data();
    logic [NREQ*WIDTH-1:0] d;
    d = '0;
    for (int i = 0; i < NREQ; i++) d[i*WIDTH +: WIDTH] = WIDTH'($urandom);
    return d;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_owner = 0; m_age = 0; m_ptr = 0; m_evt = 1'b0; m_pmod = IDLE;
  endtask

  // Advance the model by one clock, given the inputs seen during that cycle.
  task automatic model_step(input logic [NREQ-1:0] r, input logic [NREQ*WIDTH-1:0] d);
    bit leave, forced;
    int winner, idx;
    m_evt  = 1'b0;
    m_pmod = IDLE;
    if (m_busy) begin
      leave  = 1'b0;
      forced = 1'b0;
      if (m_age >= HOLD_MIN && !bit_at(r, m_owner)) leave = 1'b1;
      else if (PRIO && m_owner != 0 && m_age >= HOLD_MIN && bit_at(r, 0)) leave = 1'b1;
      else if (m_age >= TIMEOUT && (r & ~(NREQ'(1) << m_owner)) != '0) begin
        leave = 1'b1;
        forced = 1'b1;
      end
      m_evt = forced;
      if (leave) begin
        m_busy = 1'b0;
        if (!(PRIO && m_owner == 0)) m_ptr = (m_owner + 1) % NREQ;
      end else begin
        m_pmod = WIDTH'(d >> (m_owner * WIDTH));
        m_age++;
      end
    end else begin
      winner = -1;
      if (PRIO && bit_at(r, 0)) winner = 0;
      else begin
        for (int k = 0; k < NREQ; k++) begin
          idx = (m_ptr + k) % NREQ;
          if (winner < 0 && bit_at(r, idx)) winner = idx;
        end
      end
      if (winner >= 0) begin
        m_busy = 1'b1; m_owner = winner; m_age = 1;
        $display("grant: owner=%0d req=%b t=%0t", winner, r, $time);
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, ".grant"}, 32'(grant), m_busy ? (32'(1) << m_owner) : 32'd0);
    check_val({tag, ".busy"}, 32'(busy), 32'(m_busy));
    check_val({tag, ".evt"}, 32'(timeout_evt), 32'(m_evt));
    check_val({tag, ".pmod"}, 32'(pmod_out), 32'(m_pmod));
    if (m_busy) check_val({tag, ".owner"}, 32'(owner), 32'(m_owner));
  endtask

  // Drive one cycle of inputs (called at a falling edge), clock it, then compare.
  task automatic step(input bit rst, input logic [NREQ-1:0] r,
                      input logic [NREQ*WIDTH-1:0] d, input string tag);
    reset = rst; req = r; data_in = d;
    if (rst) model_reset();
    else model_step(r, d);
    @(negedge clk);
    check_outputs(tag);
  endtask

  initial begin
    logic [NREQ*WIDTH-1:0] d;
    logic [NREQ-1:0]       r;
    bit                    evt_seen;
    bit                    rst;
    int                    rel_age;

    // Reset, then no requests for 100 cycles.
    step(1'b1, '0, rand_data(), "t1_rst");
    check_val("t1_rst_owner", 32'(owner), 32'd0);
    repeat (100) step(1'b0, '0, rand_data(), "t1_idle");

    // Single requester 1, with its request dropped early.
    d = rand_data();
    d[15:8] = 8'hA5;
    step(1'b0, 4'b0010, d, "t2");
    check_val("t2_grant_t1", 32'(grant), 32'b0010);
    step(1'b0, 4'b0010, d, "t2");
    check_val("t2_pmod_t2", 32'(pmod_out), 32'hA5);
    step(1'b0, 4'b0010, d, "t2");
    repeat (13) step(1'b0, 4'b0000, d, "t2");
    check_val("t2_grant_t16", 32'(grant), 32'b0010);
    step(1'b0, 4'b0000, d, "t2");
    check_val("t2_gap_grant", 32'(grant), 32'd0);
    check_val("t2_gap_pmod", 32'(pmod_out), 32'h00);

    // All requesters held: timeout rotation 0,1,2,3,0.
    step(1'b1, '0, rand_data(), "t3_rst");
    step(1'b0, 4'hF, rand_data(), "t3");
    for (int g = 0; g < 5; g++) begin
      check_val("t3_owner", 32'(owner), 32'(g % NREQ));
      check_val("t3_busy", 32'(busy), 32'd1);
      repeat (TIMEOUT - 1) step(1'b0, 4'hF, rand_data(), "t3");
      check_val("t3_held", 32'(busy), 32'd1);
      step(1'b0, 4'hF, rand_data(), "t3");
      check_val("t3_gap_busy", 32'(busy), 32'd0);
      check_val("t3_gap_evt", 32'(timeout_evt), 32'd1);
      step(1'b0, 4'hF, rand_data(), "t3");
    end

    // Lone owner 2 keeps the port well past TIMEOUT.
    step(1'b1, '0, rand_data(), "t4_rst");
    step(1'b0, 4'b0100, rand_data(), "t4");
    evt_seen = 1'b0;
    repeat (TIMEOUT + 500) begin
      step(1'b0, 4'b0100, rand_data(), "t4");
      evt_seen = evt_seen | timeout_evt;
    end
    check_val("t4_busy", 32'(busy), 32'd1);
    check_val("t4_owner", 32'(owner), 32'd2);
    check_val("t4_no_evt", 32'(evt_seen), 32'd0);

    // Reset while owner 3 holds the port; the pointer must return to 0.
    step(1'b1, '0, rand_data(), "t5_rst");
    step(1'b0, 4'b0100, rand_data(), "t5");
    repeat (HOLD_MIN) step(1'b0, 4'b1000, rand_data(), "t5");
    step(1'b0, 4'b1000, rand_data(), "t5");
    check_val("t5_owner3", 32'(owner), 32'd3);
    repeat (3) step(1'b0, 4'b1000, rand_data(), "t5");
    step(1'b1, 4'b1010, rand_data(), "t5_midrst");
    check_val("t5_rst_grant", 32'(grant), 32'd0);
    check_val("t5_rst_pmod", 32'(pmod_out), 32'(IDLE));
    step(1'b0, 4'b1010, rand_data(), "t5");
    check_val("t5_ptr0_grant", 32'(grant), 32'b0010);

    // Owner 2; requester 0 starts asking once hold_cnt reaches 5.
    rel_age = PRIO ? HOLD_MIN : TIMEOUT;
    step(1'b1, '0, rand_data(), "t6_rst");
    step(1'b0, 4'b0100, rand_data(), "t6");
    repeat (5) step(1'b0, 4'b0100, rand_data(), "t6");
    repeat (rel_age - 6) step(1'b0, 4'b0101, rand_data(), "t6");
    check_val("t6_still_owner2", 32'(grant), 32'b0100);
    step(1'b0, 4'b0101, rand_data(), "t6");
    check_val("t6_gap_busy", 32'(busy), 32'd0);
    check_val("t6_gap_evt", 32'(timeout_evt), PRIO ? 32'd0 : 32'd1);
    step(1'b0, 4'b0101, rand_data(), "t6");
    check_val("t6_grant0", 32'(grant), 32'b0001);

    // Randomized phase: slowly toggling requests, random data, rare resets.
    step(1'b1, '0, rand_data(), "rnd_rst");
    r = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(11) == 0) r[i] = ~r[i];
      end
      rst = ($urandom_range(599) == 0);
      step(rst, r, rand_data(), "rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
